// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch front-end types: NOP encoding, FSM states, queue entry layout.
package fetch_prefetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory word request/acknowledge channel.
interface fetch_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; pointers carry an extra wrap bit so full/empty are unambiguous.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Occupancy and head-of-queue view.
  always_comb begin
    count    = wr_ptr - rd_ptr;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (wr_ptr == rd_ptr);
    pop_data = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: issues word requests, buffers returned words with their PC,
// and presents the queue head to decode through an output register.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  input  logic                          stall,
  fetch_prefetch_queue_if.master        imem,
  output logic                          inst_valid,
  output logic [31:0]                   inst_out,
  output logic [31:0]                   inst_pc
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          req_q;

  fetch_entry_t  fifo_in;
  logic [63:0]   fifo_head_raw;
  fetch_entry_t  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          load_out;
  logic          do_pop;
  logic [OW-1:0] occ;
  logic          slot_idle;
  logic          slot_b2b;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_addr;

  // Occupancy counts the output register as a queue slot so DEPTH bounds the whole front end.
  always_comb begin
    fifo_head     = fetch_entry_t'(fifo_head_raw);
    occ           = OW'(fifo_count) + OW'(inst_valid);
    slot_idle     = occ < OW'(DEPTH);
    slot_b2b      = (occ + OW'(1)) < OW'(DEPTH);
    fifo_push     = (state == FETCH_REQ) && imem.imem_ack && !redirect && !fifo_full;
    fifo_in.pc    = req_addr;
    fifo_in.instr = imem.imem_rdata;
    do_pop        = inst_valid && !stall && !redirect;
    load_out      = (!inst_valid || do_pop) && !fifo_empty && !redirect;
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (load_out),
    .flush     (redirect),
    .pop_data  (fifo_head_raw),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request FSM: issue, hold until ack, and drop the in-flight word after a redirect.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= FETCH_IDLE;
      req_q    <= 1'b0;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (slot_idle) begin
            req_q    <= 1'b1;
            req_addr <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd1;
            state    <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (imem.imem_ack) begin
              req_q <= 1'b0;
              state <= FETCH_IDLE;
            end else begin
              state <= FETCH_DISCARD;
            end
          end else if (imem.imem_ack) begin
            // The word just accepted already occupies a slot, hence the +1 in slot_b2b.
            if (slot_b2b) begin
              req_addr <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd1;
            end else begin
              req_q <= 1'b0;
              state <= FETCH_IDLE;
            end
          end
        end
        FETCH_DISCARD: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem.imem_ack) begin
            req_q <= 1'b0;
            state <= FETCH_IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= FETCH_IDLE;
        end
      endcase
    end
  end

  // Output register: refilled from the FIFO head when empty or being consumed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      inst_valid <= 1'b0;
      inst_out   <= NOP_INSTR;
      inst_pc    <= '0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
      inst_out   <= NOP_INSTR;
      inst_pc    <= '0;
    end else if (load_out) begin
      inst_valid <= 1'b1;
      inst_out   <= fifo_head.instr;
      inst_pc    <= fifo_head.pc;
    end else if (do_pop) begin
      inst_valid <= 1'b0;
      inst_out   <= NOP_INSTR;
      inst_pc    <= '0;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for the fetch prefetch queue, plus a second instance for PC wrap and async reset.
module tb_fetch_prefetch_queue;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  logic        clr2;
  logic        ack2_en;
  logic        inst_valid2;
  logic [31:0] inst_out2;
  logic [31:0] inst_pc2;

  fetch_prefetch_queue_if imem1 ();
  fetch_prefetch_queue_if imem2 ();

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .clr(clr), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .imem(imem1.master), .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc)
  );

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFFE)) dut_wrap (
    .clk(clk), .clr(clr2), .redirect(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .imem(imem2.master), .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_pc(inst_pc2)
  );

  assign imem2.imem_ack   = ack2_en & imem2.imem_req;
  assign imem2.imem_rdata = ~imem2.imem_addr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  logic [31:0] held_addr;
  logic        req_pending;
  logic        discarding;
  int unsigned wait_left;
  int unsigned latency;
  int unsigned n_issued;
  int unsigned n_pops;
  logic        ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic do_reset();
    clr = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    imem1.imem_ack = 1'b0;
    imem1.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(imem1.imem_req), 32'd0);
    check_eq("rst_addr", imem1.imem_addr, 32'h0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_out", inst_out, NOP);
    check_eq("rst_pc", inst_pc, 32'h0);
    clr = 1'b0;
    sb.delete();
    exp_addr = 32'h0;
    held_addr = 32'h0;
    req_pending = 1'b0;
    discarding = 1'b0;
    wait_left = 0;
    latency = 0;
    n_issued = 0;
    n_pops = 0;
    ovr_en = 1'b0;
    ovr_addr = '0;
    ovr_data = '0;
  endtask

  // One clock: check outputs against the scoreboard, play memory, drive inputs, predict, advance.
  task automatic step(input logic rd, input logic [31:0] rd_pc);
    logic        ack_now;
    logic [31:0] word;
    exp_t        e;
    ack_now = 1'b0;
    if (inst_valid) begin
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check_eq("inst_pc", inst_pc, sb[0].pc);
        check_eq("inst_out", inst_out, sb[0].data);
      end
    end else begin
      check_eq("empty_nop", inst_out, NOP);
    end
    if (imem1.imem_req) begin
      if (!req_pending) begin
        check_eq("req_addr", imem1.imem_addr, exp_addr);
        held_addr = exp_addr;
        exp_addr = exp_addr + 32'd1;
        req_pending = 1'b1;
        wait_left = latency;
        n_issued++;
      end else begin
        check_eq("addr_hold", imem1.imem_addr, held_addr);
      end
      if (wait_left == 0) ack_now = 1'b1;
      else wait_left--;
    end else if (req_pending) begin
      check_eq("req_dropped", 32'(imem1.imem_req), 32'd1);
    end
    word = word_for(held_addr);
    imem1.imem_ack = ack_now;
    imem1.imem_rdata = ack_now ? word : 32'hBAADF00D;
    redirect = rd;
    redirect_pc = rd_pc;
    if (inst_valid && !stall && !rd && sb.size() != 0) begin
      e = sb.pop_front();
      n_pops++;
    end
    if (ack_now && !rd && !discarding) begin
      e.pc = held_addr;
      e.data = word;
      sb.push_back(e);
    end
    if (ack_now) begin
      req_pending = 1'b0;
      discarding = 1'b0;
    end
    if (rd) begin
      sb.delete();
      exp_addr = rd_pc;
      if (req_pending) discarding = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr2 = 1'b1;
    ack2_en = 1'b0;

    // Streaming with immediate ack: valid from the third clock on, addresses 0,1,2,...
    do_reset();
    for (int c = 0; c < 20; c++) begin
      check_eq("t1_valid", 32'(inst_valid), 32'(c >= 3));
      step(1'b0, 32'h0);
    end
    check_eq("t1_pops", 32'(n_pops >= 15), 32'd1);

    // Stall: exactly DEPTH requests, then nothing until release.
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 12; c++) step(1'b0, 32'h0);
    check_eq("t2_issued", n_issued, 32'd4);
    check_eq("t2_req_low", 32'(imem1.imem_req), 32'd0);
    check_eq("t2_valid_frozen", 32'(inst_valid), 32'd1);
    stall = 1'b0;
    for (int c = 0; c < 20; c++) step(1'b0, 32'h0);
    check_eq("t2_pops", 32'(n_pops >= 4), 32'd1);

    // Five wait cycles per request; first word is DEADBEEF at pc 0.
    do_reset();
    latency = 5;
    ovr_en = 1'b1;
    ovr_addr = 32'h0;
    ovr_data = 32'hDEADBEEF;
    for (int c = 0; c < 30; c++) step(1'b0, 32'h0);
    check_eq("t3_pops", 32'(n_pops >= 2), 32'd1);

    // Redirect while waiting for ack, then again while discarding.
    do_reset();
    latency = 5;
    ovr_en = 1'b1;
    ovr_addr = 32'h0;
    ovr_data = 32'h11111111;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    check_eq("t4_req_pending", 32'(imem1.imem_req), 32'd1);
    step(1'b1, 32'h20);
    check_eq("t4_valid_after_redirect", 32'(inst_valid), 32'd0);
    step(1'b1, 32'h40);
    latency = 0;
    for (int c = 0; c < 16; c++) step(1'b0, 32'h0);
    check_eq("t4_pops", 32'(n_pops >= 8), 32'd1);

    // Redirect coinciding with ack: word dropped, queue empty next cycle.
    do_reset();
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0);
    check_eq("t5_req_high", 32'(imem1.imem_req), 32'd1);
    check_eq("t5_valid_before", 32'(inst_valid), 32'd1);
    step(1'b1, 32'h80);
    check_eq("t5_valid_after_redirect", 32'(inst_valid), 32'd0);
    for (int c = 0; c < 12; c++) step(1'b0, 32'h0);
    check_eq("t5_pops", 32'(n_pops >= 8), 32'd1);

    // PC wrap from FFFFFFFE and asynchronous reset during a pending request.
    @(posedge clk);
    #1;
    check_eq("t6_rst_addr", imem2.imem_addr, 32'hFFFFFFFE);
    clr2 = 1'b0;
    ack2_en = 1'b1;
    check_eq("t6_req_c0", 32'(imem2.imem_req), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_addr_c1", imem2.imem_addr, 32'hFFFFFFFE);
    @(posedge clk);
    #1;
    check_eq("t6_addr_c2", imem2.imem_addr, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check_eq("t6_addr_c3", imem2.imem_addr, 32'h00000000);
    check_eq("t6_valid_c3", 32'(inst_valid2), 32'd1);
    check_eq("t6_pc_c3", inst_pc2, 32'hFFFFFFFE);
    check_eq("t6_out_c3", inst_out2, 32'h00000001);
    ack2_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_req_pending", 32'(imem2.imem_req), 32'd1);
    #2;
    clr2 = 1'b1;
    #1;
    check_eq("t6_async_req", 32'(imem2.imem_req), 32'd0);
    check_eq("t6_async_valid", 32'(inst_valid2), 32'd0);
    check_eq("t6_async_out", inst_out2, NOP);
    check_eq("t6_async_pc", inst_pc2, 32'h0);
    check_eq("t6_async_addr", imem2.imem_addr, 32'hFFFFFFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
